// File: rtl/syndrome_stream_tx_if.sv
// Valid/ready stream bundle used on both the measurement side
// and the decoder-facing syndrome side of syndrome_stream_tx.
interface syndrome_stream_tx_if #(
    parameter int W = 32
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/syndrome_stream_tx.sv
// Frames GRID_WIDTH_U measurement rounds into one decode job
// (header word + packed 32-bit data words) for the decoder input.
module syndrome_stream_tx #(
    parameter int          GRID_WIDTH_X = 6,
    parameter int          GRID_WIDTH_Z = 2,
    parameter int          GRID_WIDTH_U = 5,
    parameter logic [7:0]  HEADER_TAG   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    syndrome_stream_tx_if.slave  meas_i,
    syndrome_stream_tx_if.master out_o,
    output logic                 busy_o,
    output logic [15:0]          job_id_o
);
    localparam int PU  = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int WPR = (PU + 31) / 32;
    localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RCW = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
    localparam int BW  = WPR * 32;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        LOAD,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  word_q, word_d;
    logic [RCW-1:0]  round_q, round_d;
    logic [15:0]     job_q, job_d;
    logic [BW-1:0]   buf_q, buf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            round_q <= '0;
            job_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            round_q <= round_d;
            job_q   <= job_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        round_d = round_q;
        job_d   = job_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                // The round that wakes us is consumed later, in LOAD
                if (meas_i.valid) state_d = HDR;
            end
            HDR: begin
                if (out_o.ready) state_d = LOAD;
            end
            LOAD: begin
                if (meas_i.valid) begin
                    buf_d   = BW'(meas_i.data);
                    word_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_o.ready) begin
                    if (word_q < WCW'(WPR - 1)) begin
                        word_d = word_q + 1'b1;
                    end else if (round_q < RCW'(GRID_WIDTH_U - 1)) begin
                        round_d = round_q + 1'b1;
                        state_d = LOAD;
                    end else begin
                        round_d = '0;
                        job_d   = job_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        meas_i.ready = (state_q == LOAD);
        out_o.valid  = (state_q == HDR) || (state_q == SEND);
        out_o.data   = '0;
        if (state_q == HDR)
            out_o.data = {HEADER_TAG, 8'h00, job_q};
        else if (state_q == SEND)
            out_o.data = buf_q[{word_q, 5'b0} +: 32];
        busy_o   = (state_q != IDLE);
        job_id_o = job_q;
    end
endmodule

// File: tb/tb_syndrome_stream_tx.sv
// Directed bench for syndrome_stream_tx: default 12-bit rounds
// on one instance, 40-bit rounds on a second instance.
module tb_syndrome_stream_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    syndrome_stream_tx_if #(.W(12)) ma ();
    syndrome_stream_tx_if #(.W(32)) oa ();
    syndrome_stream_tx_if #(.W(40)) mb ();
    syndrome_stream_tx_if #(.W(32)) ob ();

    logic        busy_a, busy_b;
    logic [15:0] jid_a, jid_b;

    syndrome_stream_tx dut_a (
        .clk      (clk),
        .reset    (reset),
        .meas_i   (ma),
        .out_o    (oa),
        .busy_o   (busy_a),
        .job_id_o (jid_a)
    );

    syndrome_stream_tx #(
        .GRID_WIDTH_X (10),
        .GRID_WIDTH_Z (4)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .meas_i   (mb),
        .out_o    (ob),
        .busy_o   (busy_b),
        .job_id_o (jid_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [11:0] ra[5];

    task automatic job_a(input logic [15:0] jid, input bit tog,
                         input bit hold, input int lim,
                         output int nrdy);
        logic [31:0] exp[6];
        logic [31:0] held = '0;
        bit st = 1'b0;
        int k = 0, n = 0, cyc = 0;
        nrdy = 0;
        exp[0] = {8'hA5, 8'h00, jid};
        for (int i = 0; i < 5; i++) exp[i+1] = 32'(ra[i]);
        while (n < lim && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (st) begin
                check("stall_valid", 32'(oa.valid), 32'd1);
                check("stall_data", oa.data, held);
            end
            if (cyc == 2) check("hdr_lat", 32'(oa.valid), 32'd1);
            ma.valid = hold || (k < 5);
            ma.data  = ra[(k < 5) ? k : 4];
            oa.ready = tog ? cyc[0] : 1'b1;
            if (ma.ready) nrdy++;
            if (ma.valid && ma.ready) k++;
            if (oa.valid && oa.ready) begin
                check($sformatf("a_w%0d", n), oa.data, exp[n]);
                n++;
                st = 1'b0;
            end else begin
                st   = oa.valid;
                held = oa.data;
            end
        end
        check("a_job_len", 32'(n), 32'(lim));
    endtask

    task automatic end_a(input logic [15:0] jid);
        @(negedge clk);
        check("a_busy_end", 32'(busy_a), 32'd0);
        check("a_jid_next", 32'(jid_a), 32'(16'(jid + 16'd1)));
        ma.valid = 1'b0;
    endtask

    task automatic job_b();
        logic [31:0] exp[11];
        int k = 0, n = 0, cyc = 0;
        exp[0] = 32'hA500_0000;
        for (int i = 0; i < 5; i++) begin
            exp[2*i+1] = 32'hDEAD_BEEF;
            exp[2*i+2] = 32'h0000_00AB;
        end
        while (n < 11 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mb.valid = (k < 5);
            mb.data  = 40'hAB_DEAD_BEEF;
            ob.ready = 1'b1;
            if (mb.valid && mb.ready) k++;
            if (ob.valid && ob.ready) begin
                check($sformatf("b_w%0d", n), ob.data, exp[n]);
                n++;
            end
        end
        check("b_job_len", 32'(n), 32'd11);
        check("b_rounds", 32'(k), 32'd5);
        @(negedge clk);
        check("b_busy_end", 32'(busy_b), 32'd0);
        check("b_jid_next", 32'(jid_b), 32'd1);
    endtask

    int nr;

    initial begin
        reset    = 1'b1;
        ma.valid = 1'b0;
        ma.data  = '0;
        oa.ready = 1'b0;
        mb.valid = 1'b0;
        mb.data  = '0;
        ob.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(oa.valid), 32'd0);
        check("rst_data", oa.data, 32'd0);
        check("rst_mready", 32'(ma.ready), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_jid", 32'(jid_a), 32'd0);
        check("rst_b_valid", 32'(ob.valid), 32'd0);
        reset = 1'b0;

        // T1: ready always high
        ra = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
        job_a(16'h0000, 1'b0, 1'b0, 6, nr);
        check("t1_rounds", 32'(nr), 32'd5);
        end_a(16'h0000);

        // T2: ready toggling, same sequence
        job_a(16'h0001, 1'b1, 1'b0, 6, nr);
        check("t2_rounds", 32'(nr), 32'd5);
        end_a(16'h0001);

        // T5: reset after header + 3 data words
        ra = '{12'hFFF, 12'h800, 12'h0F0, 12'h00A, 12'h555};
        job_a(16'h0002, 1'b0, 1'b0, 4, nr);
        @(negedge clk);
        reset    = 1'b1;
        ma.valid = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(oa.valid), 32'd0);
        check("t5_data", oa.data, 32'd0);
        check("t5_jid", 32'(jid_a), 32'd0);
        check("t5_busy", 32'(busy_a), 32'd0);
        reset = 1'b0;
        job_a(16'h0000, 1'b0, 1'b0, 6, nr);
        end_a(16'h0000);

        // T4: job_id wrap
        @(negedge clk);
        force dut_a.job_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.job_q;
        @(negedge clk);
        check("t4_jid_pre", 32'(jid_a), 32'h0000_FFFF);
        job_a(16'hFFFF, 1'b0, 1'b0, 6, nr);
        end_a(16'hFFFF);

        // T6: meas_valid held high throughout
        ra = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};
        job_a(16'h0000, 1'b0, 1'b1, 6, nr);
        check("t6_rounds", 32'(nr), 32'd5);
        end_a(16'h0000);

        // T3: 40-bit rounds on the second instance
        job_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
